// File: rtl/consmax_pack.sv
// consmax_pack: packs a stream of consmax output elements into LANES-wide
// words, splitting at row boundaries, and buffers completed words in a small
// FIFO. The upstream side has no backpressure. A completed word that finds the
// FIFO full is dropped, and the sticky overflow flag records the drop.
module consmax_pack #(
    parameter int DATA_BIT    = 8,
    parameter int LANES       = 4,
    parameter int ROW_LEN_BIT = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic [ROW_LEN_BIT-1:0]        cfg_row_len,
    input  logic [DATA_BIT-1:0]           idata,
    input  logic                          idata_valid,
    output logic [LANES*DATA_BIT-1:0]     odata,
    output logic [LANES-1:0]              odata_mask,
    output logic                          odata_last,
    output logic                          odata_valid,
    input  logic                          odata_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int WORD_W = LANES * DATA_BIT;
    localparam int LP_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = ROW_LEN_BIT + 1;   // holds the decoded 2^ROW_LEN_BIT
    localparam int FC_W   = $clog2(FIFO_DEPTH) + 1;

    // A zero row-length encodes the largest row, 2^ROW_LEN_BIT elements.
    function automatic logic [CNT_W-1:0] decode_len(input logic [ROW_LEN_BIT-1:0] len);
        if (len == '0) return {1'b1, {ROW_LEN_BIT{1'b0}}};
        return {1'b0, len};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [LP_W-1:0]   r_lane_ptr;
    logic [CNT_W-1:0]  r_elem_cnt;
    logic [CNT_W-1:0]  r_row_len_q;
    logic [WORD_W-1:0] r_asm;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [FC_W-1:0]   r_fcnt;
    logic              r_ovf;

    logic [WORD_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [LANES-1:0]  r_mem_mask [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];

    logic [CNT_W-1:0]  w_len_eff;
    logic              w_accept;
    logic              w_row_end;
    logic              w_lane_end;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;
    logic [LANES-1:0]  w_mask;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // Word assembly and FIFO handshake decisions for the current cycle.
    always_comb begin
        // The row length is sampled from the config only on a row's first element.
        w_len_eff   = (r_elem_cnt == '0) ? decode_len(cfg_row_len) : r_row_len_q;
        w_accept    = idata_valid & ~clr;
        w_row_end   = (r_elem_cnt + CNT_W'(1)) == w_len_eff;
        w_lane_end  = (r_lane_ptr == LP_W'(LANES - 1));
        w_word_done = w_accept & (w_row_end | w_lane_end);
        // Lanes above the pointer are still zero because the assembly register
        // is cleared whenever a word completes.
        w_word      = r_asm;
        w_mask      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LP_W'(i) == r_lane_ptr) w_word[i*DATA_BIT +: DATA_BIT] = idata;
            w_mask[i] = (LP_W'(i) <= r_lane_ptr);
        end
        w_empty = (r_fcnt == '0);
        w_full  = (r_fcnt == FC_W'(FIFO_DEPTH));
        w_pop   = ~w_empty & odata_ready & ~clr;
        // A pop on the same edge frees the slot, so a full FIFO can still take a push.
        w_push  = w_word_done & (~w_full | w_pop);
        w_drop  = w_word_done & w_full & ~w_pop;
    end

    // Control state: lane and element counters, row length, FIFO pointers, overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane_ptr  <= '0;
            r_elem_cnt  <= '0;
            r_row_len_q <= '0;
            r_asm       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
            r_ovf       <= 1'b0;
        end else if (clr) begin
            r_lane_ptr  <= '0;
            r_elem_cnt  <= '0;
            r_asm       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fcnt      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_elem_cnt == '0) r_row_len_q <= w_len_eff;
                // Counters advance even when the completed word is dropped.
                if (w_word_done) begin
                    r_lane_ptr <= '0;
                    r_asm      <= '0;
                end else begin
                    r_lane_ptr <= r_lane_ptr + LP_W'(1);
                    r_asm      <= w_word;
                end
                r_elem_cnt <= w_row_end ? '0 : r_elem_cnt + CNT_W'(1);
            end
            if (w_push) r_wptr <= ptr_next(r_wptr);
            if (w_pop)  r_rptr <= ptr_next(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + FC_W'(1);
                2'b01:   r_fcnt <= r_fcnt - FC_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // FIFO storage. Entries are reached only through the occupancy count, so
    // they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= w_word;
            r_mem_mask[r_wptr] <= w_mask;
            r_mem_last[r_wptr] <= w_row_end;
        end
    end

    assign odata_valid = ~w_empty;
    assign odata       = w_empty ? '0   : r_mem_data[r_rptr];
    assign odata_mask  = w_empty ? '0   : r_mem_mask[r_rptr];
    assign odata_last  = w_empty ? 1'b0 : r_mem_last[r_rptr];
    assign overflow    = r_ovf;
    assign fifo_cnt    = r_fcnt;

endmodule

// File: tb/tb_consmax_pack.sv
// Testbench for consmax_pack: directed scenarios plus randomized traffic,
// checked every cycle against a row/position-level behavioural model.
module tb_consmax_pack;

    localparam int DW  = 8;
    localparam int LN  = 4;
    localparam int RLB = 8;
    localparam int FD  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic [RLB-1:0]  cfg_row_len;
    logic [DW-1:0]   idata;
    logic            idata_valid;
    logic [LN*DW-1:0] odata;
    logic [LN-1:0]   odata_mask;
    logic            odata_last;
    logic            odata_valid;
    logic            odata_ready;
    logic            overflow;
    logic [$clog2(FD):0] fifo_cnt;

    consmax_pack #(.DATA_BIT(DW), .LANES(LN), .ROW_LEN_BIT(RLB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .clr(clr), .cfg_row_len(cfg_row_len),
        .idata(idata), .idata_valid(idata_valid),
        .odata(odata), .odata_mask(odata_mask), .odata_last(odata_last),
        .odata_valid(odata_valid), .odata_ready(odata_ready),
        .overflow(overflow), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  m;
        logic        l;
    } word_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t m_q[$];     // expected FIFO contents
    word_t got_q[$];   // words actually accepted from the DUT
    int    m_pos;      // element index within the current row
    int    m_len;      // length of the current row
    logic [31:0] m_acc;
    bit    m_ovf;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pos = 0;
        m_len = 0;
        m_acc = '0;
        m_ovf = 1'b0;
    endfunction

    // One clock edge of the reference behaviour, using the current inputs.
    function automatic void model_step();
        bit    pop;
        bit    last;
        int    lane;
        word_t w;
        pop = (m_q.size() > 0) && odata_ready;
        if (clr) begin
            model_reset();
            return;
        end
        if (pop) void'(m_q.pop_front());
        if (idata_valid) begin
            if (m_pos == 0) m_len = (cfg_row_len == 0) ? 256 : int'(cfg_row_len);
            lane = m_pos % LN;
            m_acc[lane*8 +: 8] = idata;
            last = (m_pos + 1 == m_len);
            if (lane == LN - 1 || last) begin
                w.d = m_acc;
                w.m = 4'((1 << (lane + 1)) - 1);
                w.l = last;
                if (m_q.size() < FD) m_q.push_back(w);
                else m_ovf = 1'b1;
                m_acc = '0;
            end
            m_pos = last ? 0 : m_pos + 1;
        end
    endfunction

    task automatic check_outputs();
        check_val("odata_valid", 64'(odata_valid), 64'(m_q.size() > 0));
        check_val("fifo_cnt",    64'(fifo_cnt),    64'(m_q.size()));
        check_val("overflow",    64'(overflow),    64'(m_ovf));
        check_val("odata",       64'(odata),       64'((m_q.size() > 0) ? m_q[0].d : 32'h0));
        check_val("odata_mask",  64'(odata_mask),  64'((m_q.size() > 0) ? m_q[0].m : 4'h0));
        check_val("odata_last",  64'(odata_last),  64'((m_q.size() > 0) ? m_q[0].l : 1'b0));
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit v, input logic [7:0] d, input logic [7:0] cfg,
                         input bit rdy, input bit c);
        idata_valid = v;
        idata       = d;
        cfg_row_len = cfg;
        odata_ready = rdy;
        clr         = c;
        #1;
        if (odata_valid && odata_ready && !clr)
            got_q.push_back({odata, odata_mask, odata_last});
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send_row(input int n, input logic [7:0] start, input logic [7:0] cfg, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, start + 8'(i), cfg, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, rdy, 1'b0);
    endtask

    task automatic expect_word(input string tag, input int idx, input logic [31:0] d,
                               input logic [3:0] m, input logic l);
        if (idx < got_q.size()) begin
            check_val({tag, "_data"}, 64'(got_q[idx].d), 64'(d));
            check_val({tag, "_mask"}, 64'(got_q[idx].m), 64'(m));
            check_val({tag, "_last"}, 64'(got_q[idx].l), 64'(l));
        end else begin
            check_val({tag, "_missing"}, 64'(got_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; cfg_row_len = '0; idata = '0;
        idata_valid = 1'b0; odata_ready = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full row of two words
        got_q.delete();
        send_row(8, 8'h01, 8'd8, 1'b1);
        idle(3, 1'b1);
        check_val("r8_count", 64'(got_q.size()), 64'd2);
        expect_word("r8_w0", 0, 32'h04030201, 4'hF, 1'b0);
        expect_word("r8_w1", 1, 32'h08070605, 4'hF, 1'b1);

        // Partial final word
        got_q.delete();
        send_row(6, 8'h01, 8'd6, 1'b1);
        idle(3, 1'b1);
        check_val("r6_count", 64'(got_q.size()), 64'd2);
        expect_word("r6_w0", 0, 32'h04030201, 4'hF, 1'b0);
        expect_word("r6_w1", 1, 32'h00000605, 4'h3, 1'b1);

        // Single-element rows
        got_q.delete();
        cycle(1'b1, 8'hA0, 8'd1, 1'b1, 1'b0);
        cycle(1'b1, 8'hA1, 8'd1, 1'b1, 1'b0);
        idle(3, 1'b1);
        check_val("r1_count", 64'(got_q.size()), 64'd2);
        expect_word("r1_w0", 0, 32'h000000A0, 4'h1, 1'b1);
        expect_word("r1_w1", 1, 32'h000000A1, 4'h1, 1'b1);

        // Overflow: fifth word dropped while stalled
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        send_row(20, 8'h01, 8'd20, 1'b0);
        check_val("ovf_full_cnt", 64'(fifo_cnt), 64'd4);
        check_val("ovf_flag", 64'(overflow), 64'd1);
        got_q.delete();
        idle(6, 1'b1);
        check_val("ovf_sticky", 64'(overflow), 64'd1);
        check_val("ovf_count", 64'(got_q.size()), 64'd4);
        expect_word("ovf_w0", 0, 32'h04030201, 4'hF, 1'b0);
        expect_word("ovf_w1", 1, 32'h08070605, 4'hF, 1'b0);
        expect_word("ovf_w2", 2, 32'h0C0B0A09, 4'hF, 1'b0);
        expect_word("ovf_w3", 3, 32'h100F0E0D, 4'hF, 1'b0);

        // Push into a full FIFO with a simultaneous pop
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check_val("clr_ovf", 64'(overflow), 64'd0);
        got_q.delete();
        send_row(19, 8'h01, 8'd20, 1'b0);
        cycle(1'b1, 8'h14, 8'd20, 1'b1, 1'b0);
        check_val("pp_cnt", 64'(fifo_cnt), 64'd4);
        check_val("pp_ovf", 64'(overflow), 64'd0);
        idle(6, 1'b1);
        check_val("pp_count", 64'(got_q.size()), 64'd5);
        expect_word("pp_w0", 0, 32'h04030201, 4'hF, 1'b0);
        expect_word("pp_w3", 3, 32'h100F0E0D, 4'hF, 1'b0);
        expect_word("pp_w4", 4, 32'h14131211, 4'hF, 1'b1);

        // Asynchronous reset mid-row with words pending
        send_row(8, 8'h31, 8'd8, 1'b0);
        send_row(3, 8'h11, 8'd8, 1'b0);
        idata_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_valid", 64'(odata_valid), 64'd0);
        check_val("rst_odata", 64'(odata), 64'd0);
        check_val("rst_mask",  64'(odata_mask), 64'd0);
        check_val("rst_last",  64'(odata_last), 64'd0);
        check_val("rst_cnt",   64'(fifo_cnt), 64'd0);
        check_val("rst_ovf",   64'(overflow), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        send_row(8, 8'h11, 8'd8, 1'b1);
        idle(3, 1'b1);
        check_val("rst_count", 64'(got_q.size()), 64'd2);
        expect_word("rst_w0", 0, 32'h14131211, 4'hF, 1'b0);
        expect_word("rst_w1", 1, 32'h18171615, 4'hF, 1'b1);

        // Randomized traffic: mid-row config changes, stalls, clears
        for (int i = 0; i < 3000; i++) begin
            bit          v;
            bit          rdy;
            bit          c;
            logic [7:0]  cfg;
            v   = ($urandom_range(0, 9) < 7);
            rdy = ((i / 64) % 3 == 1) ? 1'b0 : ($urandom_range(0, 9) < 6);
            c   = ($urandom_range(0, 299) == 0);
            cfg = ($urandom_range(0, 99) == 0) ? 8'd0 : 8'($urandom_range(1, 13));
            cycle(v, 8'($urandom), cfg, rdy, c);
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
